// File: rtl/wb_stage_param.sv
// MIPS write-back stage: MEM/WB pipeline register, load extraction/extension and
// write-data select. Optional macro WB_PERF_CNT_EN adds retired/load counters.
module wb_stage_param #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter bit ZERO_REG   = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  mem_valid,
   input  logic                  mem_stall,
   input  logic                  mem_flush,
   input  logic [DATA_W-1:0]     mem_alu_out,
   input  logic [DATA_W-1:0]     mem_rdata,
   input  logic [DATA_W-1:0]     mem_link,
   input  logic [REG_ADDR_W-1:0] mem_dest,
   input  logic                  mem_we,
   input  logic [1:0]            mem_wb_sel,
   input  logic [1:0]            mem_ld_size,
   input  logic                  mem_ld_uns,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0]     rf_wdata,
   output logic                  fwd_valid,
   output logic                  ld_misalign
`ifdef WB_PERF_CNT_EN
   ,
   output logic [31:0]           perf_retired,
   output logic [31:0]           perf_loads
`endif
);

   localparam int OFF_W = $clog2(DATA_W / 8);

   typedef struct packed {
      logic                  valid;
      logic [DATA_W-1:0]     alu;
      logic [DATA_W-1:0]     rdata;
      logic [DATA_W-1:0]     link;
      logic [REG_ADDR_W-1:0] dest;
      logic                  we;
      logic [1:0]            sel;
      logic [1:0]            size;
      logic                  uns;
   } mw_t;

   mw_t mw_q, mw_d;

   // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      mw_d = mw_q;
      if (mem_flush) begin
         mw_d.valid = 1'b0;
      end else if (!mem_stall) begin
         mw_d.valid = mem_valid;
         mw_d.alu   = mem_alu_out;
         mw_d.rdata = mem_rdata;
         mw_d.link  = mem_link;
         mw_d.dest  = mem_dest;
         mw_d.we    = mem_we;
         mw_d.sel   = mem_wb_sel;
         mw_d.size  = mem_ld_size;
         mw_d.uns   = mem_ld_uns;
      end
   end

   // NOTE: sequential state uses non-blocking assignments; reset is synchronous and clears every field.
   always_ff @(posedge clk) begin
      if (!reset_n) mw_q <= '0;
      else          mw_q <= mw_d;
   end

   logic [OFF_W-1:0]  off;
   logic [DATA_W-1:0] lane;
   logic [DATA_W-1:0] ld_data;
   logic              misalign;
   logic              is_load;
   logic              mis_eff;

   assign off  = mw_q.alu[OFF_W-1:0];
   assign lane = mw_q.rdata >> {off, 3'b000};

   always_comb begin
      ld_data  = lane;
      misalign = 1'b0;
      unique case (mw_q.size)
         2'b00: ld_data = mw_q.uns ? DATA_W'(lane[7:0]) : DATA_W'($signed(lane[7:0]));
         2'b01: begin
            ld_data  = mw_q.uns ? DATA_W'(lane[15:0]) : DATA_W'($signed(lane[15:0]));
            misalign = off[0];
         end
         2'b10: begin
            ld_data  = mw_q.uns ? DATA_W'(lane[31:0]) : DATA_W'($signed(lane[31:0]));
            misalign = |off[1:0];
         end
         default: misalign = (DATA_W == 32) ? 1'b1 : |off;
      endcase
   end

   assign is_load = (mw_q.sel == 2'b01);
   assign mis_eff = is_load & misalign;

   always_comb begin
      unique case (mw_q.sel)
         2'b01:   rf_wdata = ld_data;
         2'b10:   rf_wdata = mw_q.link;
         default: rf_wdata = mw_q.alu;
      endcase
   end

   assign rf_we       = mw_q.valid & mw_q.we & ~mis_eff & ~(ZERO_REG & (mw_q.dest == '0));
   assign rf_waddr    = mw_q.dest;
   assign fwd_valid   = rf_we;
   assign ld_misalign = mw_q.valid & mw_q.we & mis_eff;

`ifdef WB_PERF_CNT_EN
   logic [31:0] ret_q, ret_d, lds_q, lds_d;
   logic        leave;

   // A flush overrides a stall, so the occupant leaves WB in that case too.
   assign leave = mw_q.valid & (mem_flush | ~mem_stall);

   always_comb begin
      ret_d = ret_q;
      lds_d = lds_q;
      if (leave) begin
         ret_d = ret_q + 32'd1;
         if (is_load & ~misalign) lds_d = lds_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ret_q <= '0;
         lds_q <= '0;
      end else begin
         ret_q <= ret_d;
         lds_q <= lds_d;
      end
   end

   assign perf_retired = ret_q;
   assign perf_loads   = lds_q;
`endif

endmodule

// File: tb/tb_wb_stage_param.sv
// Self-checking bench for wb_stage_param (DATA_W=32): directed steps followed by
// randomized traffic checked against a transaction-level expectation model.
module tb_wb_stage_param;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        mem_valid, mem_stall, mem_flush, mem_we, mem_ld_uns;
   logic [31:0] mem_alu_out, mem_rdata, mem_link;
   logic [4:0]  mem_dest;
   logic [1:0]  mem_wb_sel, mem_ld_size;
   logic        rf_we, fwd_valid, ld_misalign;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
`ifdef WB_PERF_CNT_EN
   logic [31:0] perf_retired, perf_loads;
`endif

   wb_stage_param #(.DATA_W(32), .REG_ADDR_W(5), .ZERO_REG(1'b1)) dut (
      .clk(clk), .reset_n(reset_n),
      .mem_valid(mem_valid), .mem_stall(mem_stall), .mem_flush(mem_flush),
      .mem_alu_out(mem_alu_out), .mem_rdata(mem_rdata), .mem_link(mem_link),
      .mem_dest(mem_dest), .mem_we(mem_we), .mem_wb_sel(mem_wb_sel),
      .mem_ld_size(mem_ld_size), .mem_ld_uns(mem_ld_uns),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .fwd_valid(fwd_valid), .ld_misalign(ld_misalign)
`ifdef WB_PERF_CNT_EN
      , .perf_retired(perf_retired), .perf_loads(perf_loads)
`endif
   );

   always #5 clk = ~clk;

   // Expected view of the instruction currently sitting in WB.
   typedef struct {
      bit          we;
      bit [4:0]    waddr;
      bit [31:0]   wdata;
      bit          mis;
      bit          valid;
      bit          load_ok;
      bit          dc;      // waddr/wdata unspecified (after a flush)
   } exp_t;

   exp_t        exp_s;
   int unsigned exp_ret, exp_lds;
   int          checks = 0;
   int          errors = 0;

   function automatic exp_t zero_exp();
      exp_t e;
      e.we = 0; e.waddr = 0; e.wdata = 0; e.mis = 0; e.valid = 0; e.load_ok = 0; e.dc = 0;
      return e;
   endfunction

   // Expected result of retiring the instruction presently on the mem_* inputs.
   function automatic exp_t eval_in();
      exp_t        e;
      int unsigned off;
      bit [31:0]   lane, v;
      bit          mis, is_ld;
      off  = mem_alu_out % 4;
      lane = mem_rdata >> (8 * off);
      case (mem_ld_size)
         2'd0: begin
            v = lane % 256;
            if (!mem_ld_uns && v >= 128) v = v + 32'hFFFF_FF00;
            mis = 0;
         end
         2'd1: begin
            v = lane % 65536;
            if (!mem_ld_uns && v >= 32768) v = v + 32'hFFFF_0000;
            mis = (off % 2) != 0;
         end
         2'd2:    begin v = lane; mis = (off != 0); end
         default: begin v = lane; mis = 1; end
      endcase
      is_ld     = (mem_wb_sel == 2'd1);
      e.wdata   = is_ld ? v : (mem_wb_sel == 2'd2) ? mem_link : mem_alu_out;
      e.waddr   = mem_dest;
      e.valid   = mem_valid;
      e.we      = mem_valid && mem_we && !(is_ld && mis) && (mem_dest != 0);
      e.mis     = mem_valid && mem_we && is_ld && mis;
      e.load_ok = mem_valid && is_ld && !mis;
      e.dc      = 0;
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic drive(input logic v, input logic w, input logic [1:0] sel, input logic [1:0] sz,
                        input logic u, input logic [4:0] d, input logic [31:0] a,
                        input logic [31:0] r, input logic [31:0] l);
      mem_valid = v; mem_we = w; mem_wb_sel = sel; mem_ld_size = sz; mem_ld_uns = u;
      mem_dest = d; mem_alu_out = a; mem_rdata = r; mem_link = l;
      mem_stall = 1'b0; mem_flush = 1'b0;
   endtask

   // Advance one edge, update the expectation, then compare away from the edge.
   task automatic cycle();
      @(posedge clk);
      if (!reset_n) begin
         exp_s   = zero_exp();
         exp_ret = 0;
         exp_lds = 0;
      end else begin
         if (exp_s.valid && (mem_flush || !mem_stall)) begin
            exp_ret++;
            if (exp_s.load_ok) exp_lds++;
         end
         if (mem_flush) begin
            exp_s.valid = 0; exp_s.we = 0; exp_s.mis = 0; exp_s.load_ok = 0; exp_s.dc = 1;
         end else if (!mem_stall) begin
            exp_s = eval_in();
         end
      end
      #1;
      check("rf_we", {31'b0, rf_we}, {31'b0, exp_s.we});
      check("fwd_valid", {31'b0, fwd_valid}, {31'b0, exp_s.we});
      check("ld_misalign", {31'b0, ld_misalign}, {31'b0, exp_s.mis});
      if (!exp_s.dc) begin
         check("rf_waddr", {27'b0, rf_waddr}, {27'b0, exp_s.waddr});
         check("rf_wdata", rf_wdata, exp_s.wdata);
      end
`ifdef WB_PERF_CNT_EN
      check("perf_retired", perf_retired, exp_ret);
      check("perf_loads", perf_loads, exp_lds);
`endif
   endtask

   initial begin
      exp_s   = zero_exp();
      exp_ret = 0;
      exp_lds = 0;
      reset_n = 1'b0;
      drive(1, 1, 2'd0, 2'd0, 0, 5'd7, 32'hDEAD_BEEF, 32'h0, 32'h0);

      // Reset held two edges with a live instruction on the inputs.
      cycle();
      cycle();
      check("rst_we", {31'b0, rf_we}, 32'd0);
      check("rst_waddr", {27'b0, rf_waddr}, 32'd0);
      check("rst_wdata", rf_wdata, 32'd0);
      reset_n = 1'b1;

      // ALU result path.
      drive(1, 1, 2'd0, 2'd0, 0, 5'd8, 32'h1234_5678, 32'h0, 32'h0);
      cycle();
      check("alu_wdata", rf_wdata, 32'h1234_5678);

      // Byte load from lane 3, signed then unsigned.
      drive(1, 1, 2'd1, 2'd0, 0, 5'd9, 32'h0000_1003, 32'h80FF_7F01, 32'h0);
      cycle();
      check("lb_signed", rf_wdata, 32'hFFFF_FF80);
      drive(1, 1, 2'd1, 2'd0, 1, 5'd9, 32'h0000_1003, 32'h80FF_7F01, 32'h0);
      cycle();
      check("lb_unsigned", rf_wdata, 32'h0000_0080);

      // Halfword loads: aligned upper half, then misaligned odd offset.
      drive(1, 1, 2'd1, 2'd1, 0, 5'd10, 32'h0000_0002, 32'h8001_1234, 32'h0);
      cycle();
      drive(1, 1, 2'd1, 2'd1, 1, 5'd10, 32'h0000_0001, 32'h8001_1234, 32'h0);
      cycle();

      // Misaligned word load flags for exactly one cycle.
      drive(1, 1, 2'd1, 2'd2, 0, 5'd5, 32'h0000_0102, 32'hAABB_CCDD, 32'h0);
      cycle();
      check("mis_flag", {31'b0, ld_misalign}, 32'd1);
      drive(0, 0, 2'd0, 2'd0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
      cycle();
      check("mis_clear", {31'b0, ld_misalign}, 32'd0);

      // Register 0 suppressed; link write to r31; code 11 acts as ALU.
      drive(1, 1, 2'd0, 2'd0, 0, 5'd0, 32'h5555_AAAA, 32'h0, 32'h0);
      cycle();
      drive(1, 1, 2'd2, 2'd0, 0, 5'd31, 32'h1111_1111, 32'h0, 32'h0040_0008);
      cycle();
      check("link_wdata", rf_wdata, 32'h0040_0008);
      drive(1, 1, 2'd3, 2'd1, 0, 5'd3, 32'h0000_0001, 32'h0, 32'h7777_7777);
      cycle();

      // Stall for three cycles with changing inputs, then stall+flush.
      drive(1, 1, 2'd0, 2'd0, 0, 5'd9, 32'hCAFE_F00D, 32'h0, 32'h0);
      cycle();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 2'd0, 2'd0, 0, 5'd12, $urandom, $urandom, $urandom);
         mem_stall = 1'b1;
         cycle();
         check("stall_hold", rf_wdata, 32'hCAFE_F00D);
      end
      mem_flush = 1'b1;
      cycle();
      check("stall_flush_we", {31'b0, rf_we}, 32'd0);

      // Five retirements including two loads, starting from reset.
      reset_n = 1'b0;
      cycle();
      reset_n = 1'b1;
      drive(1, 1, 2'd0, 2'd0, 0, 5'd1, 32'h1, 32'h0, 32'h0);
      cycle();
      drive(1, 1, 2'd1, 2'd2, 0, 5'd2, 32'h4, 32'h2222_2222, 32'h0);
      cycle();
      drive(1, 1, 2'd0, 2'd0, 0, 5'd3, 32'h3, 32'h0, 32'h0);
      mem_stall = 1'b1;
      cycle();
      mem_stall = 1'b0;
      cycle();
      drive(1, 1, 2'd1, 2'd0, 1, 5'd4, 32'h2, 32'h0033_0000, 32'h0);
      cycle();
      drive(1, 1, 2'd2, 2'd0, 0, 5'd31, 32'h0, 32'h0, 32'h0040_0010);
      cycle();
      drive(0, 0, 2'd0, 2'd0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
      cycle();
`ifdef WB_PERF_CNT_EN
      check("perf_ret5", perf_retired, 32'd5);
      check("perf_lds2", perf_loads, 32'd2);
`endif

      // Randomized traffic including stalls, flushes and mid-stream resets.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom, $urandom);
         mem_stall = ($urandom_range(0, 3) == 0);
         mem_flush = ($urandom_range(0, 7) == 0);
         reset_n   = ($urandom_range(0, 49) != 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
